mem_access_ctrl: RTL

- Initiator side of the 32-bit byte-addressed memory port: turns CPU load/store requests into bram port cycles (address, write strobe, write data, read data).
- Supports byte, halfword and word accesses with sign/zero extension on loads.
- Sub-word stores use read-modify-write, because the bram always writes 4 bytes.
- Sits between the execute stage and the bram; memory is big-endian (byte at addr is bits [31:24] of the word read at addr).

---
 rtl/mem_access_ctrl_pkg.sv | 30 +++
 rtl/mem_access_ctrl_lane_unit.sv | 40 ++++
 rtl/mem_access_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory access controller: access sizes, FSM
// states and the big-endian lane geometry.
package mem_access_ctrl_pkg;

  // Access size as encoded on req_size.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

  // Big-endian lanes: the addressed byte/half sits in the top bits of the word.
  localparam int BYTE_BITS = 8;
  localparam int HALF_BITS = 16;

  // A store narrower than the bram word must read the word first.
  function automatic logic needs_rmw(input size_e size);
    return size != SZ_WORD;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_lane_unit.sv
// Combinational lane logic: extracts and extends load data from the top lanes
// of the bram word, and merges sub-word store data into the word read back.
module mem_lane_unit
  import mem_access_ctrl_pkg::*;
#(
  parameter int W = 32
) (
  input  size_e        size_i,
  input  logic         signed_i,
  input  logic [W-1:0] rdata_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] load_o,
  output logic [W-1:0] merge_o
);

  logic ext_b;
  logic ext_h;

  assign ext_b = signed_i & rdata_i[W-1];
  assign ext_h = signed_i & rdata_i[W-1];

  // Select the load result and the read-modify-write word by access size.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    load_o  = rdata_i;
    merge_o = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        load_o  = {{(W-BYTE_BITS){ext_b}}, rdata_i[W-1 -: BYTE_BITS]};
        merge_o = {wdata_i[BYTE_BITS-1:0], rdata_i[W-BYTE_BITS-1:0]};
      end
      SZ_HALF: begin
        load_o  = {{(W-HALF_BITS){ext_h}}, rdata_i[W-1 -: HALF_BITS]};
        merge_o = {wdata_i[HALF_BITS-1:0], rdata_i[W-HALF_BITS-1:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator side of the byte-addressed bram port: turns CPU load/store
// requests into bram read/write cycles, with read-modify-write for sub-word
// stores and sign/zero extension for sub-word loads.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int MEM_DEPTH  = 2250,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [ADDR_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ADDR_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic                  m_write,
  output logic [ADDR_WIDTH-1:0] m_wdata,
  input  logic [ADDR_WIDTH-1:0] m_rdata
);

  localparam int AW1 = ADDR_WIDTH + 1;

  state_e                state_q, state_d;
  logic                  we_q;
  size_e                 size_q;
  logic                  signed_q;
  logic [ADDR_WIDTH-1:0] wdata_q;
  logic [ADDR_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
  logic                  m_write_q, m_write_d;
  logic [ADDR_WIDTH-1:0] m_wdata_q, m_wdata_d;

  size_e                 req_size_e;
  logic                  accept;
  logic [AW1-1:0]        last_byte;
  logic                  req_err;
  logic                  req_word_store;
  logic [ADDR_WIDTH-1:0] load_data;
  logic [ADDR_WIDTH-1:0] merge_data;

  assign req_size_e     = size_e'(req_size);
  assign req_ready      = (state_q == ST_IDLE) && !rst;
  assign accept         = req_valid && req_ready;
  // Last byte touched, computed one bit wider so a huge address cannot wrap.
  assign last_byte      = {1'b0, req_addr} + AW1'(3);
  assign req_err        = (req_size_e == SZ_ILL) || (last_byte >= AW1'(MEM_DEPTH));
  assign req_word_store = req_we && !needs_rmw(req_size_e);

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign m_addr    = m_addr_q;
  assign m_write   = m_write_q;
  assign m_wdata   = m_wdata_q;

  mem_lane_unit #(.W(ADDR_WIDTH)) u_lane (
    .size_i   (size_q),
    .signed_i (signed_q),
    .rdata_i  (m_rdata),
    .wdata_i  (wdata_q),
    .load_o   (load_data),
    .merge_o  (merge_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_err)             state_d = ST_RESP;
          else if (req_word_store) state_d = ST_WRITE;
          else                     state_d = ST_READ;
        end
      end
      ST_READ:  state_d = we_q ? ST_WRITE : ST_RESP;
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered bram and response outputs.
  always_comb begin
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    m_addr_d    = m_addr_q;
    m_write_d   = 1'b0;
    m_wdata_d   = m_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rsp_rdata_d = '0;
          rsp_err_d   = req_err;
          if (!req_err) begin
            m_addr_d = req_addr;
            if (req_word_store) begin
              m_wdata_d = req_wdata;
              m_write_d = 1'b1;
            end
          end
        end
      end
      ST_READ: begin
        if (we_q) begin
          m_wdata_d = merge_data;
          m_write_d = 1'b1;
        end else begin
          rsp_rdata_d = load_data;
        end
      end
      default: ;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      m_addr_q    <= '0;
      m_write_q   <= 1'b0;
      m_wdata_q   <= '0;
    end else begin
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      m_addr_q    <= m_addr_d;
      m_write_q   <= m_write_d;
      m_wdata_q   <= m_wdata_d;
    end
  end

  // Request fields latched at the accepting edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q     <= 1'b0;
      size_q   <= SZ_WORD;
      signed_q <= 1'b0;
      wdata_q  <= '0;
    end else if (accept) begin
      we_q     <= req_we;
      size_q   <= req_size_e;
      signed_q <= req_signed;
      wdata_q  <= req_wdata;
    end
  end

endmodule
